// File: rtl/clk_div_debounce_pkg.sv
// Shared constants for the clock divider / button debounce front end.
//   CNT_W      : width of both divider counters
//   NUM_BTNS   : number of push-button inputs conditioned
//   PULSE_MASK : per-button mode, 1 = one-shot pulse, 0 = debounced level
package clk_div_debounce_pkg;

    localparam int unsigned CNT_W    = 31;
    localparam int unsigned NUM_BTNS = 4;

    localparam logic [NUM_BTNS-1:0] PULSE_MASK = 4'b0011;

endpackage

// File: rtl/btn_debounce_cell.sv
// One push-button conditioning cell.
//   clk   : board clock
//   rst_n : asynchronous active-low reset
//   tick  : one-cycle sample strobe in the clk domain
//   in    : raw asynchronous button input
//   out   : debounced level (PULSE=0) or one-shot pulse per press (PULSE=1)
module btn_debounce_cell
    import clk_div_debounce_pkg::*;
#(
    parameter bit PULSE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic in,
    output logic out
);

    logic r_sync1;
    logic r_sync2;
    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_tick_d;
    logic r_out;

    logic w_stable;
    logic w_pulse;
    logic w_out_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else if (tick) begin
            r_s1 <= r_sync2;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // The delayed tick marks the one cycle in which the shift register has
    // just been updated, so the pulse fires once per rising sample edge and
    // lines up with the level-mode output of the other cells.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_d <= 1'b0;
        end else begin
            r_tick_d <= tick;
        end
    end

    always_comb begin
        w_stable   = r_s1 & r_s2;
        w_pulse    = r_tick_d & w_stable & ~r_s3;
        w_out_next = PULSE ? w_pulse : w_stable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= 1'b0;
        end else begin
            r_out <= w_out_next;
        end
    end

    assign out = r_out;

endmodule

// File: rtl/clk_div_debounce.sv
// Board front end: divided sample clock, display refresh clock and four
// debounced push buttons.
//   DIV_OFFSET  : half-period minus 1 of n_clk, in clk cycles
//   DISP_OFFSET : counter bit index that drives disp_clk (0..30)
//   clk         : board clock (only clock in the block)
//   rst_n       : asynchronous active-low reset
//   btns        : raw push-button inputs
//   n_clk       : divided sample clock, 50 % duty
//   disp_clk    : display refresh clock, 50 % duty
//   b           : b[1:0] one-shot pulses, b[3:2] debounced levels
module clk_div_debounce
    import clk_div_debounce_pkg::*;
#(
    parameter logic [CNT_W-1:0] DIV_OFFSET  = 31'd5000000,
    parameter int unsigned      DISP_OFFSET = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btns,
    output logic                n_clk,
    output logic                disp_clk,
    output logic [NUM_BTNS-1:0] b
);

    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;
    logic             r_n_clk;
    logic             r_n_clk_d;
    logic             r_disp_clk;
    logic             w_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_a <= '0;
            r_n_clk <= 1'b0;
        end else if (r_cnt_a == DIV_OFFSET) begin
            r_cnt_a <= '0;
            r_n_clk <= ~r_n_clk;
        end else begin
            r_cnt_a <= r_cnt_a + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_b    <= '0;
            r_disp_clk <= 1'b0;
        end else begin
            r_cnt_b    <= r_cnt_b + CNT_W'(1);
            r_disp_clk <= r_cnt_b[DISP_OFFSET];
        end
    end

    // n_clk is never used as a clock; its registered rising edge becomes a
    // clk-domain strobe instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n_clk_d <= 1'b0;
        end else begin
            r_n_clk_d <= r_n_clk;
        end
    end

    assign w_tick = r_n_clk & ~r_n_clk_d;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce_cell #(
            .PULSE (PULSE_MASK[i])
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (w_tick),
            .in    (btns[i]),
            .out   (b[i])
        );
    end

    assign n_clk    = r_n_clk;
    assign disp_clk = r_disp_clk;

endmodule

// File: tb/tb_clk_div_debounce.sv
// Bench for clk_div_debounce: two configurations (DIV_OFFSET=2/DISP_OFFSET=1
// and DIV_OFFSET=0/DISP_OFFSET=0) share stimulus; each has its own
// sample-list model and per-cycle compare, plus directed literal checks.
module tb_clk_div_debounce;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btns = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int e        = 0;
    int pulses [2][4];

    always #5 clk = ~clk;

    // n_clk level after k edges since reset release
    function automatic logic nclk_at(input int d, input int k);
        if (k <= 0) return 1'b0;
        return ((k / (d + 1)) % 2) == 1;
    endfunction

    // tick is high in the cycle following edge k when n_clk rose at edge k
    function automatic logic tick_at(input int d, input int k);
        if (k <= 0) return 1'b0;
        return nclk_at(d, k) && !nclk_at(d, k - 1);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int D = (g == 0) ? 2 : 0;
        localparam int P = (g == 0) ? 1 : 0;

        logic       w_n_clk;
        logic       w_disp_clk;
        logic [3:0] w_b;

        int         k = 0;
        logic [3:0] in1 = '0;
        logic [3:0] in2 = '0;
        logic [3:0] s0, s1, s2;
        logic [3:0] samp_q [$];
        logic       exp_n = 1'b0;
        logic       exp_disp = 1'b0;
        logic [3:0] exp_b = '0;

        clk_div_debounce #(
            .DIV_OFFSET  (31'(D)),
            .DISP_OFFSET (P)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .btns     (btns),
            .n_clk    (w_n_clk),
            .disp_clk (w_disp_clk),
            .b        (w_b)
        );

        // Model: each tick takes one sample of the 2-cycle-delayed input.
        // Level = newest two samples high; pulse = newest three are 1,1,0 and
        // a sample was just taken.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                k        = 0;
                in1      = '0;
                in2      = '0;
                samp_q.delete();
                exp_n    = 1'b0;
                exp_disp = 1'b0;
                exp_b    = '0;
            end else begin
                k = k + 1;
                s0 = (samp_q.size() > 0) ? samp_q[0] : 4'b0000;
                s1 = (samp_q.size() > 1) ? samp_q[1] : 4'b0000;
                s2 = (samp_q.size() > 2) ? samp_q[2] : 4'b0000;
                exp_n    = nclk_at(D, k);
                exp_disp = (((k - 1) >> P) & 1) == 1;
                exp_b[3:2] = s0[3:2] & s1[3:2];
                exp_b[1:0] = tick_at(D, k - 2) ? (s0[1:0] & s1[1:0] & ~s2[1:0]) : 2'b00;
                if (tick_at(D, k - 1)) begin
                    samp_q.push_front(in2);
                    if (samp_q.size() > 3) void'(samp_q.pop_back());
                end
                in2 = in1;
                in1 = btns;
            end
        end

        always @(negedge clk) begin
            n_checks++;
            if ({w_n_clk, w_disp_clk, w_b} === {exp_n, exp_disp, exp_b}) begin
                n_pass++;
            end else begin
                $display("FAIL model_cfg%0d k=%0d: got n_clk=%b disp_clk=%b b=%b, expected n_clk=%b disp_clk=%b b=%b",
                         g, k, w_n_clk, w_disp_clk, w_b, exp_n, exp_disp, exp_b);
            end
            for (int i = 0; i < 4; i++) begin
                if (w_b[i] === 1'b1) pulses[g][i]++;
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step_to(input int n);
        while (e < n) begin
            @(posedge clk);
            e++;
        end
        #3;
    endtask

    task automatic clr_pulses();
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 4; i++)
                pulses[g][i] = 0;
    endtask

    initial begin
        clr_pulses();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_b0", 8'(g_cfg[0].w_b), 8'h00);
        chk("reset_nclk0", 8'(g_cfg[0].w_n_clk), 8'h00);
        rst_n = 1'b1;
        e = 0;

        // Dividers
        step_to(2);
        chk("nclk0_e2", 8'(g_cfg[0].w_n_clk), 8'h00);
        step_to(3);
        chk("nclk0_e3", 8'(g_cfg[0].w_n_clk), 8'h01);
        chk("disp0_e3", 8'(g_cfg[0].w_disp_clk), 8'h01);
        chk("nclk1_e3", 8'(g_cfg[1].w_n_clk), 8'h01);
        chk("disp1_e3", 8'(g_cfg[1].w_disp_clk), 8'h00);
        step_to(4);
        chk("nclk1_e4", 8'(g_cfg[1].w_n_clk), 8'h00);
        chk("disp1_e4", 8'(g_cfg[1].w_disp_clk), 8'h01);
        btns = 4'b0001;
        step_to(5);
        chk("disp0_e5", 8'(g_cfg[0].w_disp_clk), 8'h00);
        step_to(6);
        chk("nclk0_e6", 8'(g_cfg[0].w_n_clk), 8'h00);

        // Pulse button held 40 cycles
        step_to(16);
        chk("pulse0_e16", 8'(g_cfg[0].w_b), 8'h00);
        step_to(17);
        chk("pulse0_e17", 8'(g_cfg[0].w_b), 8'h01);
        step_to(18);
        chk("pulse0_e18", 8'(g_cfg[0].w_b), 8'h00);
        step_to(44);
        chk("pulse_cnt0_a", 8'(pulses[0][0]), 8'd1);
        chk("pulse_cnt1_a", 8'(pulses[1][0]), 8'd1);
        btns = 4'b0000;
        step_to(60);
        clr_pulses();
        btns = 4'b0001;
        step_to(90);
        chk("pulse_cnt0_b", 8'(pulses[0][0]), 8'd1);
        chk("pulse_cnt1_b", 8'(pulses[1][0]), 8'd1);
        btns = 4'b0000;

        // Level button
        step_to(100);
        btns = 4'b0100;
        step_to(112);
        chk("level0_e112", 8'(g_cfg[0].w_b), 8'h00);
        step_to(113);
        chk("level0_e113", 8'(g_cfg[0].w_b), 8'h04);
        step_to(140);
        chk("level0_e140", 8'(g_cfg[0].w_b), 8'h04);
        btns = 4'b0000;
        step_to(148);
        chk("level0_e148", 8'(g_cfg[0].w_b), 8'h04);
        step_to(149);
        chk("level0_e149", 8'(g_cfg[0].w_b), 8'h00);

        // Glitch between ticks
        step_to(150);
        clr_pulses();
        step_to(152);
        btns = 4'b0010;
        step_to(154);
        btns = 4'b0000;
        step_to(180);
        chk("glitch_cnt0", 8'(pulses[0][1]), 8'd0);
        chk("glitch_cnt1", 8'(pulses[1][1]), 8'd0);

        // Simultaneous press
        step_to(190);
        btns = 4'b1111;
        step_to(202);
        chk("all0_e202", 8'(g_cfg[0].w_b), 8'h00);
        step_to(203);
        chk("all0_e203", 8'(g_cfg[0].w_b), 8'h0f);
        step_to(204);
        chk("all0_e204", 8'(g_cfg[0].w_b), 8'h0c);
        step_to(230);
        chk("all0_e230", 8'(g_cfg[0].w_b), 8'h0c);
        btns = 4'b0000;

        // Reset while buttons held
        step_to(260);
        btns = 4'b0101;
        step_to(275);
        chk("mid0_e275", 8'(g_cfg[0].w_b), 8'h05);
        step_to(280);
        chk("mid0_e280", 8'(g_cfg[0].w_b), 8'h04);
        rst_n = 1'b0;
        #1;
        chk("rst_b0", 8'(g_cfg[0].w_b), 8'h00);
        chk("rst_clks0", 8'({g_cfg[0].w_n_clk, g_cfg[0].w_disp_clk}), 8'h00);
        chk("rst_b1", 8'(g_cfg[1].w_b), 8'h00);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        e = 0;
        step_to(10);
        chk("rearm0_e10", 8'(g_cfg[0].w_b), 8'h00);
        step_to(11);
        chk("rearm0_e11", 8'(g_cfg[0].w_b), 8'h05);
        step_to(12);
        chk("rearm0_e12", 8'(g_cfg[0].w_b), 8'h04);
        btns = 4'b0000;
        step_to(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
